// File: rtl/ua_pipe.sv
// ua_pipe: pipelined Tomasulo functional unit with a credit-limited, tagged output queue
// that holds each result until the CDB arbiter grants it.
module ua_pipe #(
   parameter int DATA_W     = 16,
   parameter int TAG_W      = 3,
   parameter int LATENCY    = 3,
   parameter int OUTQ_DEPTH = 4
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [TAG_W-1:0]        ID_in,
   input  logic [2:0]              op,
   input  logic [DATA_W-1:0]       Dado1,
   input  logic [DATA_W-1:0]       Dado2,
   input  logic                    flush,
   input  logic                    cdb_grant,
   output logic                    confirmacao,
   output logic [TAG_W+DATA_W-1:0] Resultado,
   output logic                    ovf,
   output logic                    busy
);
   localparam int EW = TAG_W + DATA_W + 1;
   localparam int PW = (OUTQ_DEPTH > 1) ? $clog2(OUTQ_DEPTH) : 1;
   localparam int CW = $clog2(OUTQ_DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(OUTQ_DEPTH - 1);

   logic [DATA_W-1:0]  sum, dif, res;
   logic               ov, acc, push, pop;
   logic [LATENCY-1:0] pv_q, pv_d;
   logic [EW-1:0]      pd_q [LATENCY];
   logic [EW-1:0]      pd_d [LATENCY];
   logic [EW-1:0]      mem_q [OUTQ_DEPTH];
   logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]      inflight_q, inflight_d, qcount_q, qcount_d;
   logic [EW-1:0]      head_q, head_d;

   always_comb begin
      sum = Dado1 + Dado2;
      dif = Dado1 - Dado2;
      res = (op == 3'b010) ? dif
          : (op == 3'b101) ? (Dado1 & Dado2)
          : (op == 3'b110) ? (Dado1 | Dado2)
          : (op == 3'b111) ? DATA_W'($signed(Dado1) < $signed(Dado2))
          : sum;
      ov = (op == 3'b001) ? ((Dado1[DATA_W-1] == Dado2[DATA_W-1]) && (sum[DATA_W-1] != Dado1[DATA_W-1]))
         : (op == 3'b010) ? ((Dado1[DATA_W-1] != Dado2[DATA_W-1]) && (dif[DATA_W-1] != Dado1[DATA_W-1]))
         : 1'b0;
   end

   // Credit covers both in-flight and queued results, so the queue can never overflow.
   assign issue_ready = ~CLR & (({1'b0, inflight_q} + {1'b0, qcount_q}) < (CW+1)'(OUTQ_DEPTH));
   assign confirmacao = qcount_q != '0;
   assign busy        = (inflight_q != '0) | (qcount_q != '0);
   assign Resultado   = head_q[EW-2:0];
   assign ovf         = head_q[EW-1];
   assign acc         = issue_valid & issue_ready & ~flush;
   assign push        = pv_q[LATENCY-1] & ~flush;
   assign pop         = confirmacao & cdb_grant & ~flush;

   always_comb begin
      pv_d[0] = acc & (op != 3'b000);
      pd_d[0] = {ov, ID_in, res};
      for (int i = 1; i < LATENCY; i++) begin
         pv_d[i] = pv_q[i-1] & ~flush;
         pd_d[i] = pd_q[i-1];
      end
      inflight_d = flush ? '0 : inflight_q + CW'(pv_d[0]) - CW'(push);
      qcount_d   = flush ? '0 : qcount_q + CW'(push) - CW'(pop);
      wr_d       = flush ? '0 : push ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d       = flush ? '0 : pop ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
      // An entry arriving into an (effectively) empty queue becomes head directly.
      head_d     = (qcount_d == '0) ? head_q
                 : (qcount_q == CW'(pop)) ? pd_q[LATENCY-1]
                 : mem_q[rd_d];
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         pv_q       <= '0;
         inflight_q <= '0;
         qcount_q   <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         head_q     <= '0;
      end else begin
         pv_q       <= pv_d;
         inflight_q <= inflight_d;
         qcount_q   <= qcount_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         head_q     <= head_d;
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= pd_d[i];
      if (push) mem_q[wr_q] <= pd_q[LATENCY-1];
   end
endmodule

// File: tb/tb_ua_pipe.sv
// tb_ua_pipe: directed self-checking bench for ua_pipe (DATA_W=16, TAG_W=3,
// LATENCY=3, OUTQ_DEPTH=4).
module tb_ua_pipe;
   logic        CLK = 0, CLR = 0, issue_valid = 0, flush = 0, cdb_grant = 0;
   logic [2:0]  ID_in = 0, op = 0;
   logic [15:0] Dado1 = 0, Dado2 = 0;
   logic        issue_ready, confirmacao, ovf, busy;
   logic [18:0] Resultado;
   int          errors = 0, checks = 0;

   logic [2:0]  v_op [11] = '{3'b010, 3'b111, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b001, 3'b111};
   logic [15:0] v_a  [11] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h0003, 16'h8000, 16'h8000};
   logic [15:0] v_b  [11] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h3C3C, 16'h0F0F, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
   logic [15:0] v_r  [11] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 16'h3030, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0000, 16'h0001};
   logic        v_v  [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0]  b_op [6]  = '{3'b001, 3'b010, 3'b000, 3'b110, 3'b111, 3'b101};

   ua_pipe #(.DATA_W(16), .TAG_W(3), .LATENCY(3), .OUTQ_DEPTH(4)) dut (
      .CLK(CLK), .CLR(CLR), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .ID_in(ID_in), .op(op), .Dado1(Dado1), .Dado2(Dado2), .flush(flush),
      .cdb_grant(cdb_grant), .confirmacao(confirmacao), .Resultado(Resultado),
      .ovf(ovf), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [2:0] id);
      issue_valid = v;
      op = o;
      Dado1 = a;
      Dado2 = b;
      ID_in = id;
   endtask

   function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sa, sb, s;
      sa = {a[15], a};
      sb = {b[15], b};
      case (o)
         3'b010:  s = sa - sb;
         3'b101:  s = {1'b0, a & b};
         3'b110:  s = {1'b0, a | b};
         3'b111:  s = {16'h0000, $signed(a) < $signed(b)};
         default: s = sa + sb;
      endcase
      return {(o == 3'b001 || o == 3'b010) ? (s[16] != s[15]) : 1'b0, s[15:0]};
   endfunction

   task automatic test_reset;
      #2 CLR = 1;
      #1;
      checks++; if (confirmacao !== 1'b0) begin errors++; $display("FAIL reset_conf: got %b want 0", confirmacao); end
      checks++; if (Resultado !== 19'h0) begin errors++; $display("FAIL reset_res: got %h want 0", Resultado); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      step;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b want 0", issue_ready); end
      CLR = 0;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", issue_ready); end
      step;
   endtask

   task automatic test_add;
      int n = 0;
      cdb_grant = 1;
      drive(1, 3'b001, 16'h0005, 16'h0003, 3'd2);
      step;
      drive(0, 3'b000, 0, 0, 0);
      while (!confirmacao && n < 10) begin step; n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", n); end
      checks++; if (Resultado !== 19'h2_0008) begin errors++; $display("FAIL add_res: got %h want 20008", Resultado); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", ovf); end
      step;
      checks++; if (confirmacao !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_pop: got conf=%b busy=%b want 0 0", confirmacao, busy); end
      checks++; if (Resultado !== 19'h2_0008) begin errors++; $display("FAIL add_hold: got %h want 20008", Resultado); end
   endtask

   task automatic test_arith;
      int n;
      cdb_grant = 1;
      for (int i = 0; i < 11; i++) begin
         drive(1, v_op[i], v_a[i], v_b[i], 3'(i));
         step;
         drive(0, 3'b000, 0, 0, 0);
         n = 0;
         while (!confirmacao && n < 10) begin step; n++; end
         checks++; if (n !== 3) begin errors++; $display("FAIL arith%0d_latency: got %0d want 3", i, n); end
         checks++; if (Resultado !== {3'(i), v_r[i]}) begin errors++; $display("FAIL arith%0d_res: got %h want %h", i, Resultado, {3'(i), v_r[i]}); end
         checks++; if (ovf !== v_v[i]) begin errors++; $display("FAIL arith%0d_ovf: got %b want %b", i, ovf, v_v[i]); end
         step;
      end
   endtask

   task automatic test_nop;
      logic seen = 0;
      cdb_grant = 1;
      drive(1, 3'b000, 16'h1111, 16'h2222, 3'd6);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL nop_ready: got %b want 1", issue_ready); end
      step;
      drive(0, 3'b000, 0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b want 0", busy); end
      for (int i = 0; i < 5; i++) begin seen |= confirmacao; step; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL nop_result: got conf=%b want 0", seen); end
   endtask

   task automatic test_credit;
      cdb_grant = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 3'b001, 16'h0100 + 16'(i), 16'h0010, 3'(i));
         checks++; if (issue_ready !== (i < 4)) begin errors++; $display("FAIL credit_ready%0d: got %b want %b", i, issue_ready, i < 4); end
         step;
      end
      drive(0, 3'b000, 0, 0, 0);
      repeat (4) step;
      checks++; if (confirmacao !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL credit_full: got conf=%b ready=%b want 1 0", confirmacao, issue_ready); end
      checks++; if (Resultado !== {3'd0, 16'h0110}) begin errors++; $display("FAIL credit_hold: got %h want %h", Resultado, {3'd0, 16'h0110}); end
      cdb_grant = 1;
      for (int j = 0; j < 4; j++) begin
         checks++; if (confirmacao !== 1'b1 || Resultado !== {3'(j), 16'h0110 + 16'(j)}) begin errors++; $display("FAIL credit_pop%0d: got conf=%b res=%h want 1 %h", j, confirmacao, Resultado, {3'(j), 16'h0110 + 16'(j)}); end
         step;
      end
      cdb_grant = 0;
      checks++; if (confirmacao !== 1'b0 || issue_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL credit_drained: got conf=%b ready=%b busy=%b want 0 1 0", confirmacao, issue_ready, busy); end
   endtask

   task automatic test_back_to_back;
      logic [19:0] sb [$];
      logic [19:0] exp;
      logic [15:0] a, b;
      logic [2:0]  o;
      int acc_n = 0, bad = 0, n = 0;
      for (int i = 0; i < 44; i++) begin
         o = b_op[i % 6];
         a = 16'(i * 4951);
         b = 16'(16'h4000 + i * 7);
         cdb_grant = (i >= 6);
         drive(1, o, a, b, 3'(i));
         if (issue_ready) begin
            acc_n++;
            if (o != 3'b000) begin
               exp = model(o, a, b);
               sb.push_back({exp[16], 3'(i), exp[15:0]});
            end
         end
         if (confirmacao && cdb_grant) begin
            if (sb.size() == 0) bad++;
            else begin
               exp = sb.pop_front();
               checks++; if ({ovf, Resultado} !== exp) begin errors++; $display("FAIL b2b_res: got %h want %h", {ovf, Resultado}, exp); end
            end
         end
         step;
      end
      drive(0, 3'b000, 0, 0, 0);
      cdb_grant = 1;
      while (n < 20) begin
         if (confirmacao) begin
            if (sb.size() == 0) bad++;
            else begin
               exp = sb.pop_front();
               checks++; if ({ovf, Resultado} !== exp) begin errors++; $display("FAIL b2b_drain: got %h want %h", {ovf, Resultado}, exp); end
            end
         end
         step;
         n++;
      end
      checks++; if (sb.size() != 0 || bad != 0) begin errors++; $display("FAIL b2b_count: got missing=%0d extra=%0d want 0 0", sb.size(), bad); end
      checks++; if (acc_n < 30) begin errors++; $display("FAIL b2b_throughput: got %0d accepts want >=30", acc_n); end
   endtask

   task automatic test_flush;
      logic seen = 0;
      cdb_grant = 0;
      drive(1, 3'b001, 16'h0A00, 16'h000A, 3'd1);
      step;
      drive(0, 3'b000, 0, 0, 0);
      step;
      drive(1, 3'b010, 16'h0B00, 16'h000B, 3'd2);
      step;
      drive(1, 3'b110, 16'h0C00, 16'h000C, 3'd3);
      step;
      checks++; if (confirmacao !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got conf=%b busy=%b want 1 1", confirmacao, busy); end
      drive(1, 3'b001, 16'h0D00, 16'h000D, 3'd4);
      flush = 1;
      cdb_grant = 1;
      step;
      flush = 0;
      drive(0, 3'b000, 0, 0, 0);
      checks++; if (busy !== 1'b0 || confirmacao !== 1'b0) begin errors++; $display("FAIL flush_clear: got busy=%b conf=%b want 0 0", busy, confirmacao); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
      for (int i = 0; i < 6; i++) begin seen |= confirmacao | busy; step; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_ghost: got %b want 0", seen); end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      cdb_grant = 0;
      drive(1, 3'b001, 16'h1234, 16'h1111, 3'd1);
      step;
      drive(0, 3'b000, 0, 0, 0);
      repeat (3) step;
      drive(1, 3'b001, 16'h0001, 16'h0001, 3'd6);
      step;
      drive(0, 3'b000, 0, 0, 0);
      checks++; if (confirmacao !== 1'b1 || Resultado !== {3'd1, 16'h2345}) begin errors++; $display("FAIL rmid_pre: got conf=%b res=%h want 1 %h", confirmacao, Resultado, {3'd1, 16'h2345}); end
      #3 CLR = 1;
      #1;
      checks++; if (confirmacao !== 1'b0 || Resultado !== 19'h0 || ovf !== 1'b0) begin errors++; $display("FAIL rmid_out: got conf=%b res=%h ovf=%b want 0 0 0", confirmacao, Resultado, ovf); end
      checks++; if (busy !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL rmid_busy: got busy=%b ready=%b want 0 0", busy, issue_ready); end
      #2 CLR = 0;
      step;
      cdb_grant = 1;
      drive(1, 3'b110, 16'h00F0, 16'h0F00, 3'd5);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", issue_ready); end
      step;
      drive(0, 3'b000, 0, 0, 0);
      while (!confirmacao && n < 10) begin step; n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL rmid_latency: got %0d want 3", n); end
      checks++; if (Resultado !== {3'd5, 16'h0FF0} || ovf !== 1'b0) begin errors++; $display("FAIL rmid_res: got %h ovf=%b want %h 0", Resultado, ovf, {3'd5, 16'h0FF0}); end
      step;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_done: got busy=%b want 0", busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_add;
      test_arith;
      test_nop;
      test_credit;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
